// File: rtl/branch_resolve_if.sv
// Execute-stage branch bundle: branch in, resolution pulses and fetch redirect out.
// BRANCH_STATS_EN adds the three statistics counters to the bundle.
interface branch_resolve_if #(parameter int n = 32);
  logic         br_valid;
  logic         br_ready;
  logic [2:0]   funct3;
  logic [2:0]   flags;
  logic [n-1:0] pc;
  logic [n-1:0] imm;
  logic         pred_taken;
  logic         taken;
  logic         resolved;
  logic         flush;
  logic         redir_valid;
  logic         redir_ready;
  logic [n-1:0] redir_pc;
  logic         illegal;
  logic         misalign;
`ifdef BRANCH_STATS_EN
  logic [n-1:0] stat_resolved;
  logic [n-1:0] stat_taken;
  logic [n-1:0] stat_mispred;

  modport master (
    output br_valid, funct3, flags, pc, imm, pred_taken, redir_ready,
    input  br_ready, taken, resolved, flush, redir_valid, redir_pc, illegal, misalign,
    input  stat_resolved, stat_taken, stat_mispred
  );
  modport slave (
    input  br_valid, funct3, flags, pc, imm, pred_taken, redir_ready,
    output br_ready, taken, resolved, flush, redir_valid, redir_pc, illegal, misalign,
    output stat_resolved, stat_taken, stat_mispred
  );
`else
  modport master (
    output br_valid, funct3, flags, pc, imm, pred_taken, redir_ready,
    input  br_ready, taken, resolved, flush, redir_valid, redir_pc, illegal, misalign
  );
  modport slave (
    input  br_valid, funct3, flags, pc, imm, pred_taken, redir_ready,
    output br_ready, taken, resolved, flush, redir_valid, redir_pc, illegal, misalign
  );
`endif
endinterface

// File: rtl/branch_resolve.sv
// Branch resolution: direction, next PC, mispredict flush and held fetch redirect.
// Optional counters (stat_resolved/taken/mispred) are built when BRANCH_STATS_EN is defined.
module branch_resolve #(
  parameter int n = 32
) (
  input logic            clk_i,
  input logic            rst_i,
  branch_resolve_if.slave bus
);

  typedef enum logic {IDLE, REDIRECT} state_t;

  state_t       state_q, state_d;
  logic         accept;
  logic         dir_c, illegal_c, misalign_c, mispred_c, go_redir;
  logic [n-1:0] target_c;
  logic         taken_q, resolved_q, flush_q, illegal_q, misalign_q;
  logic         taken_d, resolved_d, flush_d, illegal_d, misalign_d;
  logic [n-1:0] redir_pc_q, redir_pc_d;

  assign accept = bus.br_valid && (state_q == IDLE);

  // flags: [0] equal, [1] signed ge, [2] unsigned ge
  always_comb begin
    dir_c     = 1'b0;
    illegal_c = 1'b0;
    case (bus.funct3)
      3'b000:  dir_c = bus.flags[0];
      3'b001:  dir_c = !bus.flags[0];
      3'b100:  dir_c = !bus.flags[1];
      3'b101:  dir_c = bus.flags[1];
      3'b110:  dir_c = !bus.flags[2];
      3'b111:  dir_c = bus.flags[2];
      default: illegal_c = 1'b1;
    endcase
    target_c   = dir_c ? (bus.pc + bus.imm) : (bus.pc + {{(n-3){1'b0}}, 3'd4});
    misalign_c = dir_c && (target_c[1:0] != 2'b00);
    mispred_c  = (dir_c != bus.pred_taken);
    go_redir   = accept && mispred_c && !misalign_c;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (go_redir) state_d = REDIRECT;
      REDIRECT: if (bus.redir_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.br_ready    = (state_q == IDLE);
    bus.redir_valid = (state_q == REDIRECT);
    bus.redir_pc    = redir_pc_q;
    bus.taken       = taken_q;
    bus.resolved    = resolved_q;
    bus.flush       = flush_q;
    bus.illegal     = illegal_q;
    bus.misalign    = misalign_q;
  end

  // Pulses last exactly one cycle after the accepting edge
  always_comb begin
    taken_d    = accept && dir_c;
    resolved_d = accept;
    flush_d    = go_redir;
    illegal_d  = accept && illegal_c;
    misalign_d = accept && misalign_c;
    redir_pc_d = go_redir ? target_c : redir_pc_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      taken_q    <= 1'b0;
      resolved_q <= 1'b0;
      flush_q    <= 1'b0;
      illegal_q  <= 1'b0;
      misalign_q <= 1'b0;
      redir_pc_q <= '0;
    end else begin
      taken_q    <= taken_d;
      resolved_q <= resolved_d;
      flush_q    <= flush_d;
      illegal_q  <= illegal_d;
      misalign_q <= misalign_d;
      redir_pc_q <= redir_pc_d;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [n-1:0] stat_res_q, stat_tk_q, stat_mis_q;
  logic [n-1:0] stat_res_d, stat_tk_d, stat_mis_d;

  // Misaligned branches never count as mispredicts
  always_comb begin
    stat_res_d = stat_res_q;
    stat_tk_d  = stat_tk_q;
    stat_mis_d = stat_mis_q;
    if (accept) begin
      stat_res_d = stat_res_q + 1'b1;
      if (dir_c) stat_tk_d = stat_tk_q + 1'b1;
      if (mispred_c && !misalign_c) stat_mis_d = stat_mis_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_res_q <= '0;
      stat_tk_q  <= '0;
      stat_mis_q <= '0;
    end else begin
      stat_res_q <= stat_res_d;
      stat_tk_q  <= stat_tk_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  assign bus.stat_resolved = stat_res_q;
  assign bus.stat_taken    = stat_tk_q;
  assign bus.stat_mispred  = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: driver pushes expected resolutions, monitor pops on resolved.
module tb_branch_resolve;
  localparam int N = 32;

  typedef struct packed {
    logic        tk;
    logic        fl;
    logic        il;
    logic        ma;
    logic [31:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_resolve_if #(.n(N)) bus ();
  branch_resolve #(.n(N)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_res, m_tk, m_mis;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference direction straight from the funct3 table
  function automatic logic ref_taken(input logic [2:0] f3, input logic [2:0] fl);
    logic eq, ges, geu;
    eq = fl[0]; ges = fl[1]; geu = fl[2];
    case (f3)
      3'b000:  return eq;
      3'b001:  return !eq;
      3'b100:  return !ges;
      3'b101:  return ges;
      3'b110:  return !geu;
      3'b111:  return geu;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic pick_rr(input int mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic drive_branch(input logic [2:0] f3, input logic [2:0] fl, input logic [31:0] pc,
                              input logic [31:0] imm, input logic pred, input int rr_mode);
    exp_t e;
    logic [31:0] tgt;
    e.tk = ref_taken(f3, fl);
    tgt  = e.tk ? pc + imm : pc + 32'd4;
    e.il = (f3 == 3'b010) || (f3 == 3'b011);
    e.ma = e.tk && ((tgt % 4) != 0);
    e.fl = !e.ma && (e.tk != pred);
    e.pc = tgt;
    for (int w = 0; w < 64; w++) begin
      @(posedge clk); #1;
      bus.br_valid    = 1'b1;
      bus.funct3      = f3;
      bus.flags       = fl;
      bus.pc          = pc;
      bus.imm         = imm;
      bus.pred_taken  = pred;
      bus.redir_ready = pick_rr(rr_mode);
      if (bus.br_ready) begin
        exp_q.push_back(e);
        m_res = m_res + 1;
        if (e.tk) m_tk = m_tk + 1;
        if (e.fl) m_mis = m_mis + 1;
        return;
      end
    end
    check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int cycles, input int rr_mode);
    repeat (cycles) begin
      @(posedge clk); #1;
      bus.br_valid    = 1'b0;
      bus.redir_ready = pick_rr(rr_mode);
    end
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  // Monitor: tracks the expected redirect handshake and pops on each resolved pulse
  initial begin
    logic        m_redir;
    logic [31:0] m_pc;
    exp_t        e;
    m_redir = 1'b0;
    m_pc    = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_redir = 1'b0;
        continue;
      end
      if (bus.resolved) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resolved", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("taken", bus.taken, e.tk);
          check("flush", bus.flush, e.fl);
          check("illegal", bus.illegal, e.il);
          check("misalign", bus.misalign, e.ma);
          if (e.fl) begin
            m_redir = 1'b1;
            m_pc    = e.pc;
          end
        end
      end else begin
        check("quiet_pulses", {bus.taken, bus.flush, bus.illegal, bus.misalign}, 32'd0);
      end
      check("redir_valid", bus.redir_valid, m_redir);
      check("br_ready", bus.br_ready, !m_redir);
      if (m_redir) check("redir_pc", bus.redir_pc, m_pc);
      if (m_redir && bus.redir_ready) m_redir = 1'b0;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  st_f3[10]   = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b000, 3'b001, 3'b110, 3'b101};
    logic [2:0]  st_fl[10]   = '{3'b001, 3'b001, 3'b000, 3'b010, 3'b100, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000};
    logic        st_pr[10]   = '{1'b1,   1'b0,   1'b1,   1'b1,   1'b0,   1'b1,   1'b1,   1'b1,   1'b0,   1'b0};
    logic [31:0] rpc, rimm;

    rst = 1'b1;
    bus.br_valid = 1'b0; bus.funct3 = '0; bus.flags = '0; bus.pc = '0;
    bus.imm = '0; bus.pred_taken = 1'b0; bus.redir_ready = 1'b0;
    m_res = '0; m_tk = '0; m_mis = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_br_ready", bus.br_ready, 32'd1);
    check("reset_outputs", {bus.taken, bus.resolved, bus.flush, bus.redir_valid, bus.illegal, bus.misalign}, 32'd0);
    check("reset_redir_pc", bus.redir_pc, 32'd0);
    rst = 1'b0;

    // Directed cases
    drive_branch(3'b000, 3'b001, 32'h100, 32'h20, 1'b1, 1);
    idle(2, 1);
    drive_branch(3'b001, 3'b001, 32'h200, 32'h40, 1'b1, 0);
    idle(4, 0);
    idle(2, 1);
    drive_branch(3'b100, 3'b100, 32'hFFFF_FFF0, 32'h20, 1'b0, 1);
    idle(2, 1);
    drive_branch(3'b111, 3'b100, 32'h40, 32'h6, 1'b0, 1);
    idle(2, 1);

    // Illegal funct3 mispredict, then reset while waiting in REDIRECT
    drive_branch(3'b010, 3'b111, 32'h300, 32'h80, 1'b1, 0);
    idle(2, 0);
    rst = 1'b1;
    #1;
    check("rst_mid_redir_valid", bus.redir_valid, 32'd0);
    check("rst_mid_br_ready", bus.br_ready, 32'd1);
`ifdef BRANCH_STATS_EN
    check("rst_stat_resolved", bus.stat_resolved, 32'd0);
    check("rst_stat_taken", bus.stat_taken, 32'd0);
    check("rst_stat_mispred", bus.stat_mispred, 32'd0);
`endif
    exp_q.delete();
    m_res = '0; m_tk = '0; m_mis = '0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Ten back-to-back branches: six taken, two mispredicted
    for (int i = 0; i < 10; i++)
      drive_branch(st_f3[i], st_fl[i], 32'h1000 + 32'(i * 64), 32'h10, st_pr[i], 1);
    idle(3, 1);
    check("burst_model_resolved", m_res, 32'd10);
    check("burst_model_taken", m_tk, 32'd6);
    check("burst_model_mispred", m_mis, 32'd2);
`ifdef BRANCH_STATS_EN
    check("burst_stat_resolved", bus.stat_resolved, 32'd10);
    check("burst_stat_taken", bus.stat_taken, 32'd6);
    check("burst_stat_mispred", bus.stat_mispred, 32'd2);
`endif

    // Randomized traffic with random redirect backpressure
    for (int i = 0; i < 400; i++) begin
      rpc  = $urandom;
      rpc[1:0] = 2'b00;
      rimm = 32'($urandom_range(0, 2047)) << 1;
      if ($urandom_range(0, 1) == 1) rimm = -rimm;
      if ($urandom_range(0, 3) != 0) rimm[1] = 1'b0;
      drive_branch(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), rpc, rimm,
                   1'($urandom_range(0, 1)), 2);
      if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 3)), 2);
    end
    idle(6, 1);
    check("queue_drained", exp_q.size(), 32'd0);
`ifdef BRANCH_STATS_EN
    check("stat_resolved", bus.stat_resolved, m_res);
    check("stat_taken", bus.stat_taken, m_tk);
    check("stat_mispred", bus.stat_mispred, m_mis);
`endif
    summary();
    $finish;
  end

endmodule
